shift_sequencer: RTL

//  Multi-step shift controller for the single-step nBitShifter datapath (c: 00=<<1, 01=pass, 10=>>1, 11=zero).

---
 rtl/shift_sequencer_pkg.sv | 18 +
 rtl/shift_sequencer.sv | 93 +++++++++
 2 files changed

// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the multi-step shift sequencer and the single-step
// shifter it drives: shifter control codes and the sequencer state encoding.
package shift_sequencer_pkg;

  // Single-step shifter control codes (shifter input c)
  localparam logic [1:0] SH_LEFT  = 2'b00;
  localparam logic [1:0] SH_PASS  = 2'b01;
  localparam logic [1:0] SH_RIGHT = 2'b10;
  localparam logic [1:0] SH_ZERO  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_ZERO  = 2'b10,
    ST_DONE  = 2'b11
  } seq_state_t;

endpackage

// File: rtl/shift_sequencer.sv
// Multi-step shift controller. Drives an external single-step shifter one
// position per clock and feeds its output back into a work register until the
// requested amount is used up. Shifts of N or more collapse to a single
// zeroing step.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int N     = 4,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dir,
  input  logic [AMT_W-1:0] amount,
  input  logic [N-1:0]     dataIn,
  output logic             busy,
  output logic             done,
  output logic [N-1:0]     result,
  output logic [1:0]       shCtrl,
  output logic [N-1:0]     shIn,
  input  logic [N-1:0]     shOut
);

  // Width-extended N so amounts at or beyond the datapath width compare cleanly
  localparam logic [AMT_W:0]   N_EXT   = (AMT_W+1)'(N);
  localparam logic [AMT_W-1:0] CNT_ONE = AMT_W'(1);
  localparam logic [AMT_W-1:0] CNT_NIL = '0;

  seq_state_t       state;
  logic [N-1:0]     work;
  logic [AMT_W-1:0] cnt;
  logic             dirReg;

  // Moore status outputs decoded from the state register
  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);
  assign shIn = work;

  // Shifter control: transparent except while stepping or zeroing
  always_comb begin
    shCtrl = SH_PASS;
    case (state)
      ST_SHIFT: shCtrl = dirReg ? SH_RIGHT : SH_LEFT;
      ST_ZERO:  shCtrl = SH_ZERO;
      default:  shCtrl = SH_PASS;
    endcase
  end

  // Sequencer FSM with work register, step counter and result register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      work   <= '0;
      cnt    <= '0;
      dirReg <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            work   <= dataIn;
            cnt    <= amount;
            dirReg <= dir;
            if (amount == CNT_NIL)
              state <= ST_DONE;
            else if ({1'b0, amount} >= N_EXT)
              state <= ST_ZERO;
            else
              state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          work <= shOut;
          if (cnt != CNT_NIL)
            cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE)
            state <= ST_DONE;
        end
        ST_ZERO: begin
          work  <= shOut;
          state <= ST_DONE;
        end
        ST_DONE: begin
          result <= work;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
